main_ram_arbiter: RTL and testbench
===================================

Name: main_ram_arbiter

Overview:
- Shares the single-port 32-bit main RAM (15-bit word address, byte write enables, 1-cycle registered read latency) between three requesters.
  - Port 0: host/CPU register interface.
  - Port 1: layer renderer fetch.
  - Port 2: sprite renderer fetch.
- Sits directly in front of main_ram. Drives its bus_* inputs from the granted port and routes the returned read data and a per-port valid pulse.
- Priority: fixed for port 0, round-robin between ports 1 and 2, and a starvation override so renderers cannot be locked out.

Parameters:
- ADDR_W, 15, word address width; matches the RAM.
- STARVE_LIMIT, 15, number of consecutive waiting cycles after which port 1/2 preempts port 0; legal range 1..255.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- req  in  3  request per port; bit n = port n
- write  in  3  per-port write flag (1 = write, 0 = read)
- addr  in  3*ADDR_W  per-port word address; port n at [n*ADDR_W +: ADDR_W]
- wrdata  in  96  per-port write data; port n at [n*32 +: 32]
- wrbytesel  in  12  per-port byte enables; port n at [n*4 +: 4]
- ack  out  3  one-hot grant, combinational, same cycle as the RAM access
- rddata  out  32  RAM read data, shared by all ports
- rdvalid  out  3  one-hot; pulses the cycle after a granted read
- ram_addr  out  ADDR_W  to RAM bus_addr
- ram_wrdata  out  32  to RAM bus_wrdata
- ram_wrbytesel  out  4  to RAM bus_wrbytesel
- ram_write  out  1  to RAM bus_write
- ram_rddata  in  32  from RAM bus_rddata

Behaviour:
- Handshake
  - A requester holds req, write, addr, wrdata and wrbytesel stable until it sees ack.
  - ack is high for exactly the cycle the access is presented to the RAM.
  - The requester may drop req or issue the next request in the cycle after ack.
  - Back-to-back grants to the same port are allowed.
- Grant selection (combinational, evaluated every cycle, at most one ack):
  1. Starved port 1 or 2 (starve counter >= STARVE_LIMIT). If both are starved, choose by rr_next.
  2. Otherwise port 0 if req[0].
  3. Otherwise port 1/2 by rr_next. If only one of them requests, it wins regardless of rr_next.
- rr_next register
  - Reset value 0, meaning port 1 preferred.
  - Set to the other port whenever port 1 or 2 is granted. Unchanged on port-0 grants and idle cycles.
- Starve counters (ports 1 and 2, 8-bit each, reset 0)
  - Increment, saturating at 255, each cycle req is high and ack is low.
  - Clear to 0 on ack or when req is low.
- RAM drive
  - ram_addr, ram_wrdata and ram_wrbytesel are muxed from the granted port.
  - When idle they are muxed from port 0; they are don't-care because ram_write is 0.
  - ram_write = write of the granted port AND grant valid.
- Read return
  - Register rd_port[2:0] = ack & ~write on every clock edge; reset 0.
  - rdvalid = rd_port.
  - rddata = ram_rddata (pass-through); valid only while some rdvalid bit is high.
- Write grants
  - Produce ack only. A write is complete at the clock edge ending the ack cycle.
  - A read to the same address acked in a later cycle returns the new data.
- Reset
  - While rst is high: ack = 0, ram_write = 0, rdvalid = 0, counters and rr_next at their reset values.
  - A read acked in the cycle rst asserts produces no rdvalid.
  - On deassert, arbitration resumes from the reset state.
- Latency
  - Uncontended: ack in the request cycle; read data with rdvalid 1 cycle later.
  - Port 1/2 under continuous port-0 traffic: worst-case wait is STARVE_LIMIT cycles, plus 1 cycle when both renderers are starved.

Decomposition:
- Shared package constants:
  - PORT_HOST = 0, PORT_LAYER = 1, PORT_SPRITE = 2
  - NUM_PORTS = 3
  - RAM_DATA_W = 32
  - RAM_BYTESEL_W = 4
- One natural sub-module, main_ram_arb_starve: a per-port saturating wait counter with a starved flag output, instantiated for ports 1 and 2.
- Grant logic, round-robin register, RAM mux and read-return pipeline stay in the top module.

Test Plan:
- Single port-0 write then read. Write addr 0x0123, data 0xDEADBEEF, sel 0xF; next cycle read 0x0123 -> ack[0] each cycle; rdvalid = 001 one cycle after the read ack; rddata = 0xDEADBEEF.
- Byte-masked write. Write 0x11223344 sel 0x5 over 0xAAAAAAAA, then read -> rddata = 0xAA22AA44.
- Round-robin. req = 110 held for 4 cycles with reads -> ack sequence 010, 100, 010, 100; rdvalid follows one cycle later.
- Starvation. req[0] held continuously and req[1] held, STARVE_LIMIT = 15 -> ack[0] for 15 cycles, then ack = 010 on cycle 16, then port 0 resumes.
- Both starved. req = 111 continuous -> after 15 port-0 grants, ports 1 and 2 are each granted once in rr order before port 0 regains the bus.
- Reset mid-read. Port-2 read acked, rst asserted in the same cycle -> no rdvalid pulse, ram_write = 0, counters 0; after release, req = 110 grants port 1 first.

Source files
------------

// File: rtl/main_ram_arbiter_pkg.sv
// Shared constants and helpers for the main RAM arbiter.
// Port indices, RAM bus widths and the starve counter width live here so the
// top and the starve counter agree on them.
package main_ram_arbiter_pkg;

  localparam int unsigned NUM_PORTS     = 3;
  localparam int unsigned PORT_HOST     = 0;
  localparam int unsigned PORT_LAYER    = 1;
  localparam int unsigned PORT_SPRITE   = 2;

  localparam int unsigned RAM_DATA_W    = 32;
  localparam int unsigned RAM_BYTESEL_W = 4;

  localparam int unsigned PORT_SEL_W    = 2;
  localparam int unsigned STARVE_CNT_W  = 8;

  typedef logic [PORT_SEL_W-1:0] port_sel_t;

  // One-hot vector for a port index.
  function automatic logic [NUM_PORTS-1:0] port_onehot(input port_sel_t sel);
    return NUM_PORTS'(1) << sel;
  endfunction

endpackage

// File: rtl/main_ram_arb_starve.sv
// Per-port saturating wait counter for the main RAM arbiter.
// Counts cycles a port requests without being granted; starved_c is high
// while the port is requesting and has waited at least LIMIT cycles.
//   clk, rst   : clock, asynchronous active-high reset
//   req        : this port's request
//   ack        : this port's grant in the current cycle
//   starved_c  : combinational starved flag, feeds grant selection
module main_ram_arb_starve
  import main_ram_arbiter_pkg::*;
#(
  parameter int unsigned LIMIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic req,
  input  logic ack,
  output logic starved_c
);

  localparam logic [STARVE_CNT_W-1:0] CNT_MAX = '1;

  logic [STARVE_CNT_W-1:0] cnt;

  // Wait counter: cleared on grant or when idle, saturates at its maximum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (!req || ack) begin
      cnt <= '0;
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + STARVE_CNT_W'(1);
    end
  end

  // Gated by req so a counter left over from a dropped request cannot win.
  assign starved_c = req && (cnt >= STARVE_CNT_W'(LIMIT));

endmodule

// File: rtl/main_ram_arbiter.sv
// Three-port arbiter in front of the single-port main RAM.
// Port 0 (host) has fixed priority, ports 1/2 (layer/sprite renderers)
// alternate round-robin, and a renderer that has waited STARVE_LIMIT cycles
// preempts the host.
//   clk, rst        : clock, asynchronous active-high reset
//   req/write/addr/wrdata/wrbytesel : per-port request buses
//   ack             : one-hot grant, combinational, same cycle as RAM access
//   rddata/rdvalid  : shared read data, one-hot valid one cycle after a read
//   ram_*           : RAM bus (1-cycle registered read latency)
module main_ram_arbiter
  import main_ram_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W       = 15,
  parameter int unsigned STARVE_LIMIT = 15
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NUM_PORTS-1:0]                  req,
  input  logic [NUM_PORTS-1:0]                  write,
  input  logic [NUM_PORTS*ADDR_W-1:0]           addr,
  input  logic [NUM_PORTS*RAM_DATA_W-1:0]       wrdata,
  input  logic [NUM_PORTS*RAM_BYTESEL_W-1:0]    wrbytesel,
  output logic [NUM_PORTS-1:0]                  ack,
  output logic [RAM_DATA_W-1:0]                 rddata,
  output logic [NUM_PORTS-1:0]                  rdvalid,
  output logic [ADDR_W-1:0]                     ram_addr,
  output logic [RAM_DATA_W-1:0]                 ram_wrdata,
  output logic [RAM_BYTESEL_W-1:0]              ram_wrbytesel,
  output logic                                  ram_write,
  input  logic [RAM_DATA_W-1:0]                 ram_rddata
);

  logic                 rr_next;      // 0: layer preferred, 1: sprite preferred
  logic [NUM_PORTS-1:0] rd_port;
  logic                 starved_layer;
  logic                 starved_sprite;
  logic                 grant_valid;
  port_sel_t            grant_sel;
  port_sel_t            rr_pick;

  main_ram_arb_starve #(.LIMIT(STARVE_LIMIT)) u_starve_layer (
    .clk       (clk),
    .rst       (rst),
    .req       (req[PORT_LAYER]),
    .ack       (ack[PORT_LAYER]),
    .starved_c (starved_layer)
  );

  main_ram_arb_starve #(.LIMIT(STARVE_LIMIT)) u_starve_sprite (
    .clk       (clk),
    .rst       (rst),
    .req       (req[PORT_SPRITE]),
    .ack       (ack[PORT_SPRITE]),
    .starved_c (starved_sprite)
  );

  // Grant selection: starved renderer, then host, then renderers round-robin.
  // Idle selects the host so the RAM mux has a defined source.
  always_comb begin
    grant_valid = 1'b0;
    grant_sel   = port_sel_t'(PORT_HOST);
    rr_pick     = rr_next ? port_sel_t'(PORT_SPRITE) : port_sel_t'(PORT_LAYER);
    if (!rst) begin
      if (starved_layer && starved_sprite) begin
        grant_valid = 1'b1;
        grant_sel   = rr_pick;
      end else if (starved_layer) begin
        grant_valid = 1'b1;
        grant_sel   = port_sel_t'(PORT_LAYER);
      end else if (starved_sprite) begin
        grant_valid = 1'b1;
        grant_sel   = port_sel_t'(PORT_SPRITE);
      end else if (req[PORT_HOST]) begin
        grant_valid = 1'b1;
        grant_sel   = port_sel_t'(PORT_HOST);
      end else if (req[PORT_LAYER] && req[PORT_SPRITE]) begin
        grant_valid = 1'b1;
        grant_sel   = rr_pick;
      end else if (req[PORT_LAYER]) begin
        grant_valid = 1'b1;
        grant_sel   = port_sel_t'(PORT_LAYER);
      end else if (req[PORT_SPRITE]) begin
        grant_valid = 1'b1;
        grant_sel   = port_sel_t'(PORT_SPRITE);
      end
    end
  end

  assign ack = grant_valid ? port_onehot(grant_sel) : '0;

  // RAM bus driven from the selected port.
  always_comb begin
    ram_addr      = addr[32'(grant_sel)*ADDR_W +: ADDR_W];
    ram_wrdata    = wrdata[32'(grant_sel)*RAM_DATA_W +: RAM_DATA_W];
    ram_wrbytesel = wrbytesel[32'(grant_sel)*RAM_BYTESEL_W +: RAM_BYTESEL_W];
    ram_write     = grant_valid & write[grant_sel];
  end

  // Round-robin pointer and read-return pipeline.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_next <= 1'b0;
      rd_port <= '0;
    end else begin
      rd_port <= ack & ~write;
      if (ack[PORT_LAYER]) begin
        rr_next <= 1'b1;
      end else if (ack[PORT_SPRITE]) begin
        rr_next <= 1'b0;
      end
    end
  end

  assign rdvalid = rd_port;
  assign rddata  = ram_rddata;

endmodule

// File: tb/tb_main_ram_arbiter.sv
// Scoreboard bench for main_ram_arbiter with a behavioural RAM model.
// Stimulus drives directed per-cycle vectors and queues the hand-computed
// grants and read returns (tagged with the cycle they are due); the monitor
// pops and compares whenever ack or rdvalid is non-zero.
module tb_main_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req;
  logic [2:0]  write;
  logic [44:0] addr;
  logic [95:0] wrdata;
  logic [11:0] wrbytesel;
  logic [2:0]  ack;
  logic [31:0] rddata;
  logic [2:0]  rdvalid;
  logic [14:0] ram_addr;
  logic [31:0] ram_wrdata;
  logic [3:0]  ram_wrbytesel;
  logic        ram_write;
  logic [31:0] ram_rddata;

  main_ram_arbiter #(.ADDR_W(15), .STARVE_LIMIT(15)) dut (
    .clk           (clk),
    .rst           (rst),
    .req           (req),
    .write         (write),
    .addr          (addr),
    .wrdata        (wrdata),
    .wrbytesel     (wrbytesel),
    .ack           (ack),
    .rddata        (rddata),
    .rdvalid       (rdvalid),
    .ram_addr      (ram_addr),
    .ram_wrdata    (ram_wrdata),
    .ram_wrbytesel (ram_wrbytesel),
    .ram_write     (ram_write),
    .ram_rddata    (ram_rddata)
  );

  always #5 clk = ~clk;

  // RAM: byte-enabled write, registered read.
  logic [31:0] mem [0:32767];
  always @(posedge clk) begin
    if (ram_write) begin
      for (int b = 0; b < 4; b++) begin
        if (ram_wrbytesel[b]) mem[ram_addr][b*8 +: 8] <= ram_wrdata[b*8 +: 8];
      end
    end
    ram_rddata <= mem[ram_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; logic [2:0] ack; } ack_exp_t;
  typedef struct { int cyc; logic [2:0] port; logic [31:0] data; } rd_exp_t;
  ack_exp_t ack_q[$];
  rd_exp_t  rd_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_ack(input logic [2:0] a);
    ack_q.push_back('{cyc, a});
  endtask

  task automatic push_rd(input logic [2:0] p, input logic [31:0] d);
    rd_q.push_back('{cyc + 1, p, d});
  endtask

  task automatic set_port(input int p, input logic w, input logic [14:0] a,
                          input logic [31:0] d, input logic [3:0] s);
    write[p]             = w;
    addr[p*15 +: 15]     = a;
    wrdata[p*32 +: 32]   = d;
    wrbytesel[p*4 +: 4]  = s;
  endtask

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  // Monitor: compares each presented grant / read return against the queues.
  always @(negedge clk) begin
    if (ack !== 3'b000) begin
      n_tests++;
      if (ack_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_ack: got %b at cycle %0d, none expected", ack, cyc);
      end else begin
        ack_exp_t e;
        e = ack_q.pop_front();
        if (ack !== e.ack || cyc != e.cyc) begin
          n_fail++;
          $display("FAIL ack: got %b at cycle %0d expected %b at cycle %0d",
                   ack, cyc, e.ack, e.cyc);
        end
      end
    end
    if (rdvalid !== 3'b000) begin
      n_tests++;
      if (rd_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_rdvalid: got %b data %h at cycle %0d",
                 rdvalid, rddata, cyc);
      end else begin
        rd_exp_t r;
        r = rd_q.pop_front();
        if (rdvalid !== r.port || rddata !== r.data || cyc != r.cyc) begin
          n_fail++;
          $display("FAIL rdvalid: got %b/%h at cycle %0d expected %b/%h at cycle %0d",
                   rdvalid, rddata, cyc, r.port, r.data, r.cyc);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; req = '0; write = '0; addr = '0; wrdata = '0; wrbytesel = '0;
    step(); step();
    check("reset_ack", 32'(ack), 32'd0);
    check("reset_ram_write", 32'(ram_write), 32'd0);
    check("reset_rdvalid", 32'(rdvalid), 32'd0);

    // Host write then read back.
    step(); rst = 1'b0;
    set_port(0, 1'b1, 15'h0123, 32'hDEADBEEF, 4'hF); req = 3'b001; push_ack(3'b001);
    step(); set_port(0, 1'b0, 15'h0123, '0, '0); push_ack(3'b001); push_rd(3'b001, 32'hDEADBEEF);

    // Byte-masked write over a known word.
    step(); set_port(0, 1'b1, 15'h0200, 32'hAAAAAAAA, 4'hF); push_ack(3'b001);
    step(); set_port(0, 1'b1, 15'h0200, 32'h11223344, 4'h5); push_ack(3'b001);
    step(); set_port(0, 1'b0, 15'h0200, '0, '0); push_ack(3'b001); push_rd(3'b001, 32'hAA22AA44);

    // Round-robin between renderers; layer reads 0x0123, sprite reads 0x0200.
    step(); req = 3'b000;
    set_port(1, 1'b0, 15'h0123, '0, '0);
    set_port(2, 1'b0, 15'h0200, '0, '0);
    for (int i = 0; i < 4; i++) begin
      step(); req = 3'b110;
      if (i % 2 == 0) begin push_ack(3'b010); push_rd(3'b010, 32'hDEADBEEF); end
      else            begin push_ack(3'b100); push_rd(3'b100, 32'hAA22AA44); end
    end
    // Lone sprite request wins although layer is preferred.
    step(); req = 3'b100; push_ack(3'b100); push_rd(3'b100, 32'hAA22AA44);
    step(); req = 3'b000;

    // Layer starvation under continuous host reads.
    for (int i = 0; i < 15; i++) begin
      step(); req = 3'b011; push_ack(3'b001); push_rd(3'b001, 32'hAA22AA44);
    end
    step(); req = 3'b011; push_ack(3'b010); push_rd(3'b010, 32'hDEADBEEF);
    step(); req = 3'b001; push_ack(3'b001); push_rd(3'b001, 32'hAA22AA44);
    step(); req = 3'b000;

    // Both renderers starved; last renderer grant was layer so sprite goes first.
    for (int i = 0; i < 15; i++) begin
      step(); req = 3'b111; push_ack(3'b001); push_rd(3'b001, 32'hAA22AA44);
    end
    step(); req = 3'b111; push_ack(3'b100); push_rd(3'b100, 32'hAA22AA44);
    step(); req = 3'b011; push_ack(3'b010); push_rd(3'b010, 32'hDEADBEEF);
    step(); req = 3'b001; push_ack(3'b001); push_rd(3'b001, 32'hAA22AA44);
    step(); req = 3'b000;

    // Reset lands while a sprite read is being acked.
    step(); req = 3'b100; push_ack(3'b100);
    @(negedge clk); #1; rst = 1'b1; #1;
    check("rst_mid_ack", 32'(ack), 32'd0);
    check("rst_mid_ram_write", 32'(ram_write), 32'd0);
    check("rst_mid_rdvalid", 32'(rdvalid), 32'd0);
    step();
    check("rst_no_rdvalid", 32'(rdvalid), 32'd0);
    check("rst_hold_ack", 32'(ack), 32'd0);
    step(); rst = 1'b0; req = 3'b110; push_ack(3'b010); push_rd(3'b010, 32'hDEADBEEF);
    step(); req = 3'b100; push_ack(3'b100); push_rd(3'b100, 32'hAA22AA44);
    step(); req = 3'b000;
    step(); step();

    check("ack_queue_drained", 32'(ack_q.size()), 32'd0);
    check("rd_queue_drained", 32'(rd_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
